// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and the peripheral
// register block that feeds it.
package uart_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      BUSY  = 2'd2
   } state_t;

   localparam int DEF_DEPTH     = 8;
   localparam int DEF_EN_CYCLES = 327;

   // Register addresses of the CPU-visible TX data and control registers.
   localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
   localparam logic [31:0] ADDR_CON = 32'h4000_0020;

endpackage

// File: rtl/uart_tx_sched_if.sv
// CPU-side and sender-side signals of the transmit scheduler, bundled so the
// peripheral block and the scheduler connect through one port.
interface uart_tx_sched_if #(
   parameter int AW = 3
);
   logic          push;
   logic [7:0]    push_data;
   logic          clr;
   logic          tx_status;
   logic          tx_en;
   logic [7:0]    tx_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          busy;
   logic          done;
   logic          ovf;
   logic          tout;

   modport slave (
      input  push, push_data, clr, tx_status,
      output tx_en, tx_data, full, empty, count, busy, done, ovf, tout
   );

   modport master (
      output push, push_data, clr, tx_status,
      input  tx_en, tx_data, full, empty, count, busy, done, ovf, tout
   );
endinterface

// File: rtl/uart_tx_sched_fifo.sv
// Circular byte FIFO with a separate occupancy counter; a push on a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int W     = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          drop
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign drop     = push && !do_push;
   assign pop_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; occupancy and pointers alone
   // decide which entries are valid, so clearing the data would be wasted.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: queues CPU bytes and launches them one at a time over
// the sender's tx_en/tx_status handshake, with sticky overflow/timeout flags.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AW        = 3,
   parameter int EN_CYCLES = DEF_EN_CYCLES,
   parameter int CW        = 9
) (
   input  logic            clk,
   input  logic            reset,
   uart_tx_sched_if.slave  bus
);

   localparam logic [CW-1:0] CNT_LAST = CW'(EN_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          tx_en;
   logic [7:0]    tx_data;
   logic          done;
   logic          ovf;
   logic          tout;

   logic          pop;
   logic          tout_set;
   logic          fifo_drop;
   logic [7:0]    head;
   logic          full;
   logic          empty;
   logic [AW:0]   count;

   // The byte is popped in the same cycle it is captured into tx_data.
   assign pop      = (state == IDLE) && !empty && bus.tx_status;
   assign tout_set = (state == DRIVE) && bus.tx_status && (cnt == CNT_LAST);

   sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.push),
      .push_data (bus.push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .drop      (fifo_drop)
   );

   // NOTE: every register below uses <= so all next-state values are
   // computed from the pre-edge values, whatever the statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         tx_en   <= 1'b0;
         tx_data <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= head;
                  tx_en   <= 1'b1;
                  cnt     <= '0;
                  state   <= DRIVE;
               end
            end
            DRIVE: begin
               cnt <= cnt + 1'b1;
               // Acceptance wins over a timeout landing on the same edge.
               if (!bus.tx_status || tout_set) begin
                  tx_en <= 1'b0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (bus.tx_status) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               tx_en <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Sticky flags: a set event in the same cycle as clr takes priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf  <= 1'b0;
         tout <= 1'b0;
      end else begin
         ovf  <= fifo_drop | (ovf  & ~bus.clr);
         tout <= tout_set  | (tout & ~bus.clr);
      end
   end

   assign bus.tx_en   = tx_en;
   assign bus.tx_data = tx_data;
   assign bus.done    = done;
   assign bus.ovf     = ovf;
   assign bus.tout    = tout;
   assign bus.busy    = (state != IDLE);
   assign bus.full    = full;
   assign bus.empty   = empty;
   assign bus.count   = count;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_tx_sched;

   localparam int DEPTH = 8;
   localparam int EN    = 327;

   logic clk;
   logic reset;

   uart_tx_sched_if #(.AW(3)) bus();

   uart_tx_sched #(
      .DEPTH     (DEPTH),
      .AW        (3),
      .EN_CYCLES (EN),
      .CW        (9)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queue plus the life cycle of the launched byte.
   logic [7:0] q[$];
   bit         m_launched = 0;
   bit         m_tx_en    = 0;
   bit         m_done     = 0;
   bit         m_ovf      = 0;
   bit         m_tout     = 0;
   logic [7:0] m_tx_data  = '0;
   int         m_held     = 0;

   task automatic model_reset();
      q.delete();
      m_launched = 0; m_tx_en = 0; m_done = 0;
      m_ovf = 0; m_tout = 0; m_tx_data = '0; m_held = 0;
   endtask

   task automatic model_step();
      bit popped;
      bit ovf_set;
      bit tout_set;
      popped   = !m_launched && (q.size() > 0) && bus.tx_status;
      ovf_set  = 0;
      tout_set = 0;
      m_done   = 0;
      if (popped) begin
         m_tx_data  = q.pop_front();
         m_launched = 1;
         m_tx_en    = 1;
         m_held     = 1;
      end else if (m_launched && m_tx_en) begin
         if (!bus.tx_status) m_tx_en = 0;
         else if (m_held == EN) begin
            m_tx_en  = 0;
            tout_set = 1;
         end else m_held++;
      end else if (m_launched && bus.tx_status) begin
         m_done     = 1;
         m_launched = 0;
      end
      if (bus.push) begin
         if (q.size() < DEPTH) q.push_back(bus.push_data);
         else ovf_set = 1;
      end
      m_ovf  = ovf_set  || (m_ovf  && !bus.clr);
      m_tout = tout_set || (m_tout && !bus.clr);
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else model_step();
   end

   // Observed history for the directed scenarios.
   logic [7:0] sent[$];
   int         runs[$];
   int         done_cnt = 0;
   int         max_cnt  = 0;
   bit         prev_en  = 0;
   int         run_len  = 0;

   always @(negedge clk) begin
      if (reset) begin
         check("tx_en",   bus.tx_en,   m_tx_en);
         check("tx_data", bus.tx_data, m_tx_data);
         check("count",   bus.count,   q.size());
         check("full",    bus.full,    q.size() == DEPTH);
         check("empty",   bus.empty,   q.size() == 0);
         check("busy",    bus.busy,    m_launched);
         check("done",    bus.done,    m_done);
         check("ovf",     bus.ovf,     m_ovf);
         check("tout",    bus.tout,    m_tout);
         if (bus.tx_en && !prev_en) sent.push_back(bus.tx_data);
         if (bus.tx_en) run_len++;
         else if (prev_en) begin
            runs.push_back(run_len);
            run_len = 0;
         end
         prev_en = bus.tx_en;
         if (bus.done) done_cnt++;
         if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      end else begin
         prev_en = 0;
         run_len = 0;
      end
   end

   // Sender model: 1 = stuck idle, 2 = stuck busy, 0 = accepts after
   // acc_delay cycles of tx_en and stays busy for busy_len cycles.
   int smode     = 1;
   int acc_delay = 0;
   int busy_len  = 0;
   int acc_cnt   = 0;
   int busy_cnt  = 0;

   always @(negedge clk) begin
      case (smode)
         1: bus.tx_status = 1'b1;
         2: bus.tx_status = 1'b0;
         default: begin
            if (bus.tx_status) begin
               if (bus.tx_en) begin
                  if (acc_cnt >= acc_delay) begin
                     bus.tx_status = 1'b0;
                     busy_cnt = 0;
                     acc_cnt  = 0;
                  end else acc_cnt++;
               end else acc_cnt = 0;
            end else begin
               if (busy_cnt >= busy_len) begin
                  bus.tx_status = 1'b1;
                  busy_cnt = 0;
               end else busy_cnt++;
            end
         end
      endcase
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_push(input logic [7:0] b);
      bus.push      = 1'b1;
      bus.push_data = b;
      cyc();
      bus.push      = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int i = 0;
      while ((q.size() != 0 || m_launched) && i < budget) begin
         cyc();
         i++;
      end
      check(name, i < budget, 1);
      cyc(2);
   endtask

   function automatic logic [31:0] sent_at(input int i);
      return (i < sent.size()) ? 32'(sent[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] run_at(input int i);
      return (i < runs.size()) ? 32'(runs[i]) : 32'hFFFF_FFFF;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.push      = 1'b0;
      bus.push_data = '0;
      bus.clr       = 1'b0;
      bus.tx_status = 1'b1;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("rst_tx_en",   bus.tx_en,   0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_count",   bus.count,   0);
      check("rst_empty",   bus.empty,   1);
      check("rst_full",    bus.full,    0);
      check("rst_busy",    bus.busy,    0);
      check("rst_done",    bus.done,    0);
      check("rst_ovf",     bus.ovf,     0);
      check("rst_tout",    bus.tout,    0);
      cyc(3);
      reset = 1'b1;
      cyc(2);

      // Single byte: accept 3 cycles after tx_en rises, busy 10 cycles.
      smode = 0; acc_delay = 3; busy_len = 10;
      sent.delete(); runs.delete(); done_cnt = 0;
      cyc(2);
      do_push(8'hA5);
      check("single_lat_en0", bus.tx_en, 0);
      check("single_cnt1",    bus.count, 1);
      cyc();
      check("single_lat_en1", bus.tx_en, 1);
      check("single_cnt0",    bus.count, 0);
      check("single_data",    bus.tx_data, 8'hA5);
      wait_drain("single_drain", 200);
      check("single_run",  run_at(0), 4);
      check("single_done", done_cnt, 1);
      check("single_sent", sent.size(), 1);
      check("single_flags", {bus.ovf, bus.tout}, 0);

      // Burst: fill while the sender is busy, then drain in order.
      smode = 2;
      cyc(2);
      sent.delete(); done_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         bus.push = 1'b1;
         bus.push_data = 8'(i);
         cyc();
      end
      bus.push = 1'b0;
      check("burst_full",  bus.full,  1);
      check("burst_count", bus.count, 8);
      acc_delay = 2; busy_len = 20; busy_cnt = 0;
      smode = 0;
      wait_drain("burst_drain", 2000);
      for (int i = 0; i < 8; i++) check($sformatf("burst_byte%0d", i), sent_at(i), i + 1);
      check("burst_done",  done_cnt, 8);
      check("burst_empty", bus.empty, 1);

      // Overflow, clr, then push on full together with a pop.
      smode = 2;
      cyc(2);
      sent.delete();
      for (int i = 0; i < 8; i++) do_push(8'(8'h30 + i));
      do_push(8'hFF);
      check("ovf_set",   bus.ovf,   1);
      check("ovf_count", bus.count, 8);
      bus.clr = 1'b1;
      cyc();
      bus.clr = 1'b0;
      check("ovf_clr", bus.ovf, 0);
      acc_delay = 2; busy_len = 0; busy_cnt = 0;
      smode = 0;
      do_push(8'h99);
      check("fullpop_count", bus.count, 8);
      check("fullpop_ovf",   bus.ovf,   0);
      wait_drain("ovf_drain", 2000);
      check("ovf_sent_n", sent.size(), 9);
      for (int i = 0; i < 8; i++) check($sformatf("ovf_byte%0d", i), sent_at(i), 8'h30 + i);
      check("ovf_byte8", sent_at(8), 8'h99);

      // Timeout: sender never accepts.
      smode = 1;
      cyc(2);
      sent.delete(); runs.delete();
      do_push(8'h5A);
      do_push(8'h5B);
      wait_drain("tout_drain", 1200);
      check("tout_run0", run_at(0), 327);
      check("tout_run1", run_at(1), 327);
      check("tout_flag", bus.tout, 1);
      check("tout_order", {sent_at(0), sent_at(1)}, {32'h5A, 32'h5B});
      bus.clr = 1'b1;
      cyc();
      bus.clr = 1'b0;
      check("tout_clr", bus.tout, 0);

      // Acceptance on the last allowed cycle beats the timeout.
      runs.delete();
      smode = 0; acc_delay = 326; busy_len = 3; acc_cnt = 0;
      cyc(2);
      do_push(8'h77);
      wait_drain("prio_drain", 600);
      check("prio_run",  run_at(0), 327);
      check("prio_tout", bus.tout, 0);

      // Reset while driving with bytes queued.
      smode = 1;
      cyc(2);
      for (int i = 0; i < 4; i++) do_push(8'(8'hC1 + i));
      cyc(3);
      check("pre_rst_en", bus.tx_en, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_en",    bus.tx_en,   0);
      check("mid_rst_count", bus.count,   0);
      check("mid_rst_data",  bus.tx_data, 0);
      check("mid_rst_busy",  bus.busy,    0);
      cyc();
      reset = 1'b1;
      base = sent.size();
      cyc(20);
      check("post_rst_quiet", sent.size(), base);

      // Pointer wrap: 20 bytes with occupancy kept at 1-3.
      smode = 0; acc_delay = 1; busy_len = 1; acc_cnt = 0; busy_cnt = 0;
      cyc(2);
      sent.delete(); max_cnt = 0;
      for (int b = 0; b < 20; b++) begin
         int g = 0;
         while (q.size() > 1 && g < 100) begin
            cyc();
            g++;
         end
         cyc($urandom_range(0, 3));
         do_push(8'(8'h10 + b));
      end
      wait_drain("wrap_drain", 500);
      for (int i = 0; i < 20; i++) check($sformatf("wrap_byte%0d", i), sent_at(i), 8'h10 + i);
      check("wrap_max_le3", max_cnt <= 3, 1);
      check("wrap_max_ge1", max_cnt >= 1, 1);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) begin
            smode     = ($urandom_range(0, 3) == 0) ? 2 : 0;
            acc_delay = $urandom_range(0, 5);
            busy_len  = $urandom_range(0, 6);
         end
         bus.push      = ($urandom_range(0, 9) < 4);
         bus.push_data = 8'($urandom);
         bus.clr       = ($urandom_range(0, 19) == 0);
         cyc();
      end
      bus.push = 1'b0;
      bus.clr  = 1'b0;
      smode = 0;
      wait_drain("rand_drain", 3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
